// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, FSM encoding and address-field helpers for cache_ctrl_nway
package cache_pkg;

  localparam int ADDR_W_DEF      = 16;
  localparam int WORD_W_DEF      = 16;
  localparam int SETS_DEF        = 64;
  localparam int N_WAYS_DEF      = 2;
  localparam int BLOCK_WORDS_DEF = 8;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

  localparam int OFF_W = clog2(BLOCK_WORDS_DEF);
  localparam int IDX_W = clog2(SETS_DEF);
  localparam int TAG_W = ADDR_W_DEF - 1 - OFF_W - IDX_W;
  localparam int LRU_W = (N_WAYS_DEF > 1) ? clog2(N_WAYS_DEF) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    DONE = 2'b10
  } state_e;

  // Byte address layout, LSB first: byte bit | word offset | set index | tag
  function automatic int unsigned addr_off(input int unsigned addr, input int off_w);
    return (addr >> 1) & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic int unsigned addr_idx(input int unsigned addr, input int off_w, input int idx_w);
    return (addr >> (1 + off_w)) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic int unsigned addr_tag(input int unsigned addr, input int off_w, input int idx_w);
    return addr >> (1 + off_w + idx_w);
  endfunction

endpackage

// File: rtl/cache_ctrl_nway_if.sv
// rtl/cache_ctrl_nway_if.sv - requester and memory-side signal bundle for cache_ctrl_nway
interface cache_ctrl_nway_if #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16
);
  logic              req_vld;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [WORD_W-1:0] rdata;
  logic              hit;
  logic              fsm_busy;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_rvld;

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, mem_rdata, mem_rvld,
    output rdata, hit, fsm_busy, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, mem_rdata, mem_rvld,
    input  rdata, hit, fsm_busy, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - true-LRU age update and victim selection for one set
module cache_lru #(
  parameter int N_WAYS = 2,
  parameter int AGE_W  = 1
) (
  input  logic [N_WAYS*AGE_W-1:0] ages_i,
  input  logic [N_WAYS-1:0]       valid_i,
  input  logic [AGE_W-1:0]        way_i,
  output logic [N_WAYS*AGE_W-1:0] ages_o,
  output logic [AGE_W-1:0]        victim_o
);
  logic [AGE_W-1:0] old_age;

  always_comb begin
    ages_o   = ages_i;
    victim_o = '0;
    old_age  = ages_i[way_i*AGE_W +: AGE_W];
    for (int w = 0; w < N_WAYS; w++) begin
      if (AGE_W'(w) == way_i) begin
        ages_o[w*AGE_W +: AGE_W] = '0;
      end else if (ages_i[w*AGE_W +: AGE_W] < old_age) begin
        ages_o[w*AGE_W +: AGE_W] = ages_i[w*AGE_W +: AGE_W] + 1'b1;
      end
    end
    for (int w = 0; w < N_WAYS; w++) begin
      if (ages_i[w*AGE_W +: AGE_W] == AGE_W'(N_WAYS - 1)) victim_o = AGE_W'(w);
    end
    // Descending scan so the lowest-numbered invalid way wins over the oldest way
    for (int w = N_WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) victim_o = AGE_W'(w);
    end
  end
endmodule

// File: rtl/cache_ctrl_nway.sv
// rtl/cache_ctrl_nway.sv - set-associative write-through/write-allocate cache with miss-fill FSM
module cache_ctrl_nway
  import cache_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WORD_W      = WORD_W_DEF,
  parameter int SETS        = SETS_DEF,
  parameter int N_WAYS      = N_WAYS_DEF,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
  input logic              clk,
  input logic              rst,
  cache_ctrl_nway_if.slave bus
);
  localparam int OW = clog2(BLOCK_WORDS);
  localparam int IW = clog2(SETS);
  localparam int TW = ADDR_W - 1 - OW - IW;
  localparam int AW = (N_WAYS > 1) ? clog2(N_WAYS) : 1;

  logic [WORD_W-1:0]    data_q  [N_WAYS][SETS*BLOCK_WORDS];
  logic [TW-1:0]        tag_q   [N_WAYS][SETS];
  logic [N_WAYS-1:0]    valid_q [SETS];
  logic [N_WAYS*AW-1:0] age_q   [SETS];

  state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [AW-1:0]     victim_q;
  logic [OW:0]       issue_cnt_q;
  logic [OW-1:0]     ret_cnt_q;

  logic [OW-1:0] req_off;
  logic [IW-1:0] req_idx, fill_idx, lru_set;
  logic [TW-1:0] req_tag, fill_tag;
  logic [AW-1:0] hit_way, lru_way, lru_victim;
  logic [N_WAYS*AW-1:0] lru_ages;
  logic          way_hit, hit;

  assign req_off  = OW'(addr_off(32'(bus.req_addr), OW));
  assign req_idx  = IW'(addr_idx(32'(bus.req_addr), OW, IW));
  assign req_tag  = TW'(addr_tag(32'(bus.req_addr), OW, IW));
  assign fill_idx = IW'(addr_idx(32'(base_q), OW, IW));
  assign fill_tag = TW'(addr_tag(32'(base_q), OW, IW));

  always_comb begin
    way_hit = 1'b0;
    hit_way = '0;
    for (int w = N_WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && tag_q[w][req_idx] == req_tag) begin
        way_hit = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  assign hit          = bus.req_vld && way_hit && (state_q == IDLE);
  assign bus.hit      = hit;
  assign bus.rdata    = hit ? data_q[hit_way][{req_idx, req_off}] : '0;
  assign bus.fsm_busy = (bus.req_vld && !hit) || (state_q != IDLE);

  // One LRU evaluator: the requested set while idle, the filled set on completion
  assign lru_set = (state_q == DONE) ? fill_idx : req_idx;
  assign lru_way = (state_q == DONE) ? victim_q : hit_way;

  cache_lru #(.N_WAYS(N_WAYS), .AGE_W(AW)) u_lru (
    .ages_i   (age_q[lru_set]),
    .valid_i  (valid_q[lru_set]),
    .way_i    (lru_way),
    .ages_o   (lru_ages),
    .victim_o (lru_victim)
  );

  always_comb begin
    state_d       = state_q;
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (hit && bus.req_wr) begin
          bus.mem_en    = 1'b1;
          bus.mem_wr    = 1'b1;
          bus.mem_addr  = bus.req_addr;
          bus.mem_wdata = bus.req_wdata;
        end
        if (bus.req_vld && !hit) state_d = FILL;
      end
      FILL: begin
        // issue_cnt MSB set means all BLOCK_WORDS reads are out
        if (!issue_cnt_q[OW]) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = base_q | ADDR_W'({issue_cnt_q[OW-1:0], 1'b0});
        end
        if (bus.mem_rvld && ret_cnt_q == '1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      victim_q    <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < N_WAYS; w++) age_q[s][w*AW +: AW] <= AW'(w);
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.req_vld && !hit) begin
            base_q                       <= {bus.req_addr[ADDR_W-1:OW+1], {(OW+1){1'b0}}};
            victim_q                     <= lru_victim;
            valid_q[req_idx][lru_victim] <= 1'b0;
            issue_cnt_q                  <= '0;
            ret_cnt_q                    <= '0;
          end else if (hit) begin
            age_q[req_idx] <= lru_ages;
          end
        end
        FILL: begin
          if (!issue_cnt_q[OW]) issue_cnt_q <= issue_cnt_q + 1'b1;
          if (bus.mem_rvld)     ret_cnt_q   <= ret_cnt_q + 1'b1;
        end
        DONE: begin
          valid_q[fill_idx][victim_q] <= 1'b1;
          age_q[fill_idx]             <= lru_ages;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (hit && bus.req_wr)                data_q[hit_way][{req_idx, req_off}]   <= bus.req_wdata;
      if (state_q == FILL && bus.mem_rvld)  data_q[victim_q][{fill_idx, ret_cnt_q}] <= bus.mem_rdata;
      if (state_q == DONE)                  tag_q[victim_q][fill_idx]             <= fill_tag;
    end
  end
endmodule
